// File: rtl/io_channel_unit.sv
// Eight-channel I/O register file with an outbound peripheral queue.
// Optional same-cycle core-write read bypass: define IO_READ_BYPASS_EN.
module io_channel_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IO_write_en,
    input  logic [2:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    input  logic [2:0]  IO_read_sel,
    output logic [14:0] IO_read_data,
    input  logic        in_valid,
    input  logic [2:0]  in_chan,
    input  logic [14:0] in_data,
    output logic        periph_valid,
    input  logic        periph_ready,
    output logic [2:0]  periph_chan,
    output logic [14:0] periph_data,
    output logic        io_stall,
    output logic        overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [14:0]   ch_q  [8];
    logic [17:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic wr_ok;
    logic deq;
    logic full;
    logic enq;
    logic drop;

    always_comb begin
        wr_ok = IO_write_en && (IO_write_sel != 3'd0);
        full  = (count_q == CW'(DEPTH));
        deq   = (count_q != '0) && periph_ready;
        // A full queue still takes the write when the head leaves this cycle.
        enq   = wr_ok && (!full || deq);
        drop  = wr_ok && full && !deq;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                ch_q[i[2:0]] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i[PW-1:0]] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // CH0 is never written; core write outranks inbound on a collision.
            for (int unsigned i = 1; i < 8; i++) begin
                if (wr_ok && (IO_write_sel == i[2:0])) begin
                    ch_q[i[2:0]] <= IO_write_data;
                end else if (in_valid && (in_chan == i[2:0])) begin
                    ch_q[i[2:0]] <= in_data;
                end
            end

            if (enq) begin
                mem_q[tail_q] <= {IO_write_sel, IO_write_data};
                tail_q        <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            if (enq && !deq) begin
                count_q <= count_q + 1'b1;
            end else if (deq && !enq) begin
                count_q <= count_q - 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
`ifdef IO_READ_BYPASS_EN
        if (wr_ok && (IO_write_sel == IO_read_sel)) begin
            IO_read_data = IO_write_data;
        end else begin
            IO_read_data = ch_q[IO_read_sel];
        end
`else
        IO_read_data = ch_q[IO_read_sel];
`endif
    end

    always_comb begin
        periph_valid              = (count_q != '0);
        {periph_chan, periph_data} = mem_q[head_q];
        io_stall                  = full;
        overflow                  = overflow_q;
    end

endmodule

// File: tb/tb_io_channel_unit.sv
// Bench for io_channel_unit: directed stimulus, outbound entries checked
// by a scoreboard monitor on each completed peripheral handshake.
module tb_io_channel_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        IO_write_en;
    logic [2:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [2:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        in_valid;
    logic [2:0]  in_chan;
    logic [14:0] in_data;
    logic        periph_valid;
    logic        periph_ready;
    logic [2:0]  periph_chan;
    logic [14:0] periph_data;
    logic        io_stall;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    logic [17:0] sb[$];

    io_channel_unit #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .IO_write_en  (IO_write_en),
        .IO_write_sel (IO_write_sel),
        .IO_write_data(IO_write_data),
        .IO_read_sel  (IO_read_sel),
        .IO_read_data (IO_read_data),
        .in_valid     (in_valid),
        .in_chan      (in_chan),
        .in_data      (in_data),
        .periph_valid (periph_valid),
        .periph_ready (periph_ready),
        .periph_chan  (periph_chan),
        .periph_data  (periph_data),
        .io_stall     (io_stall),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [14:0] data);
        IO_write_en   = 1'b1;
        IO_write_sel  = sel;
        IO_write_data = data;
    endtask

    task automatic idle();
        IO_write_en = 1'b0;
        in_valid    = 1'b0;
    endtask

    // Monitor: each handshake seen mid-cycle must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && periph_valid && periph_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got %0h expected none", {periph_chan, periph_data});
            end else begin
                if ({periph_chan, periph_data} !== sb[0]) begin
                    failures++;
                    $display("FAIL sb_entry: got %0h expected %0h", {periph_chan, periph_data}, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        IO_write_en = 1'b0; IO_write_sel = '0; IO_write_data = '0;
        IO_read_sel = '0; in_valid = 1'b0; in_chan = '0; in_data = '0;
        periph_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;

        // Reset state
        IO_read_sel = 3'd5;
        chk("rst_valid", periph_valid, 0);
        chk("rst_stall", io_stall, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_chan", periph_chan, 0);
        chk("rst_data", periph_data, 0);
        chk("rst_rd5", IO_read_data, 0);

        // Single write to ch5, read same cycle and next
        wr(3'd5, 15'o12345);
        #1;
`ifdef IO_READ_BYPASS_EN
        chk("wr5_same_rd", IO_read_data, 15'o12345);
`else
        chk("wr5_same_rd", IO_read_data, 0);
`endif
        sb.push_back({3'd5, 15'o12345});
        cyc(); idle();
        chk("wr5_valid", periph_valid, 1);
        chk("wr5_chan", periph_chan, 5);
        chk("wr5_data", periph_data, 15'o12345);
        chk("wr5_rd", IO_read_data, 15'o12345);
        periph_ready = 1'b1;
        cyc();
        periph_ready = 1'b0;
        chk("wr5_drained", periph_valid, 0);

        // Write to ch0 is ignored
        wr(3'd0, 15'o777);
        IO_read_sel = 3'd0;
        cyc(); idle();
        chk("ch0_noenq", periph_valid, 0);
        chk("ch0_rd", IO_read_data, 0);

        // Fill, then overflow on a fifth write
        wr(3'd1, 15'o1); sb.push_back({3'd1, 15'o1}); cyc();
        wr(3'd2, 15'o2); sb.push_back({3'd2, 15'o2}); cyc();
        wr(3'd3, 15'o3); sb.push_back({3'd3, 15'o3}); cyc();
        chk("fill3_stall", io_stall, 0);
        wr(3'd4, 15'o4); sb.push_back({3'd4, 15'o4}); cyc();
        chk("fill4_stall", io_stall, 1);
        chk("fill4_ovf", overflow, 0);
        wr(3'd3, 15'o7);
        IO_read_sel = 3'd3;
        cyc(); idle();
        chk("ovf_set", overflow, 1);
        chk("ovf_ch3", IO_read_data, 15'o7);
        chk("ovf_stall", io_stall, 1);
        chk("ovf_head_chan", periph_chan, 1);
        chk("ovf_head_data", periph_data, 15'o1);
        cyc();
        chk("ovf_sticky", overflow, 1);

        // Reset mid-transfer with a concurrent write: everything discarded
        reset = 1'b1;
        wr(3'd6, 15'o66);
        cyc();
        reset = 1'b0; idle();
        sb.delete();
        IO_read_sel = 3'd6;
        #1;
        chk("rst2_valid", periph_valid, 0);
        chk("rst2_stall", io_stall, 0);
        chk("rst2_ovf", overflow, 0);
        chk("rst2_chan", periph_chan, 0);
        chk("rst2_data", periph_data, 0);
        chk("rst2_rd6", IO_read_data, 0);

        // Full queue, simultaneous enqueue and dequeue
        wr(3'd1, 15'o11); sb.push_back({3'd1, 15'o11}); cyc();
        wr(3'd2, 15'o22); sb.push_back({3'd2, 15'o22}); cyc();
        wr(3'd3, 15'o33); sb.push_back({3'd3, 15'o33}); cyc();
        wr(3'd4, 15'o44); sb.push_back({3'd4, 15'o44}); cyc();
        chk("full_stall", io_stall, 1);
        wr(3'd5, 15'o55); sb.push_back({3'd5, 15'o55});
        periph_ready = 1'b1;
        cyc(); idle();
        chk("swap_stall", io_stall, 1);
        chk("swap_ovf", overflow, 0);
        chk("swap_head", periph_chan, 2);
        repeat (4) cyc();
        periph_ready = 1'b0;
        chk("swap_drained", periph_valid, 0);
        chk("swap_nostall", io_stall, 0);

        // Core write vs inbound on ch2; inbound-only updates
        wr(3'd2, 15'o111);
        in_valid = 1'b1; in_chan = 3'd2; in_data = 15'o222;
        sb.push_back({3'd2, 15'o111});
        cyc(); idle();
        IO_read_sel = 3'd2;
        #1;
        chk("coll_ch2", IO_read_data, 15'o111);
        in_valid = 1'b1; in_chan = 3'd7; in_data = 15'o321;
        cyc();
        in_chan = 3'd0; in_data = 15'o5;
        IO_read_sel = 3'd7;
        #1;
        chk("in_ch7", IO_read_data, 15'o321);
        chk("in_noenq_chan", periph_chan, 2);
        cyc(); idle();
        IO_read_sel = 3'd0;
        #1;
        chk("in_ch0", IO_read_data, 0);
        periph_ready = 1'b1;
        cyc();
        periph_ready = 1'b0;
        chk("coll_drained", periph_valid, 0);

        // Read of ch4 during a write to ch4
        IO_read_sel = 3'd4;
        wr(3'd4, 15'o55);
        sb.push_back({3'd4, 15'o55});
        #1;
`ifdef IO_READ_BYPASS_EN
        chk("byp_same", IO_read_data, 15'o55);
`else
        chk("byp_same", IO_read_data, 15'o44);
`endif
        cyc(); idle();
        chk("byp_next", IO_read_data, 15'o55);
        periph_ready = 1'b1;
        cyc();
        periph_ready = 1'b0;
        cyc();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_channel_unit.md
IO_CHANNEL_UNIT -- requirements
Module: io_channel_unit

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries in the outbound peripheral queue (power of two, 2..16).
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset is synchronous and active-high.
REQ-004 Port: IO_write_en  input  1  core writeback-stage channel write strobe.
REQ-005 Port: IO_write_sel  input  3  channel number of the core write.
REQ-006 Port: IO_write_data  input  15  data of the core write.
REQ-007 Port: IO_read_sel  input  3  channel selected by the core decode stage.
REQ-008 Port: IO_read_data  output  15  channel value returned to the core decode stage, combinational.
REQ-009 Port: in_valid  input  1  peripheral inbound channel update strobe.
REQ-010 Port: in_chan  input  3  channel number of the inbound update.
REQ-011 Port: in_data  input  15  data of the inbound update.
REQ-012 Port: periph_valid  output  1  outbound queue head is valid.
REQ-013 Port: periph_ready  input  1  peripheral accepts the head this cycle.
REQ-014 Port: periph_chan  output  3  channel number of the queue head.
REQ-015 Port: periph_data  output  15  data of the queue head.
REQ-016 Port: io_stall  output  1  queue full; the core must hold its writeback stage.
REQ-017 Port: overflow  output  1  sticky flag: a core write was dropped.

Function
REQ-018 Holds eight 15-bit channel registers CH0..CH7. CH0 always reads 0 and ignores all writes.
REQ-019 A core write with IO_write_en=1 and IO_write_sel!=0 updates CH[IO_write_sel] at the next edge.
REQ-020 A core write with IO_write_en=1 and IO_write_sel!=0 also enqueues {IO_write_sel, IO_write_data} into the outbound queue.
REQ-021 An inbound update with in_valid=1 and in_chan!=0 updates CH[in_chan] at the next edge; no enqueue.
REQ-022 Same-cycle core write and inbound update to the same channel: the core write wins; the inbound value is discarded.
REQ-023 IO_read_data = CH[IO_read_sel] (read-forwarding per REQ-032/033).
REQ-024 Outbound queue: DEPTH-entry FIFO with a head pointer, a tail pointer, and a count of 0..DEPTH; pointers wrap modulo DEPTH.
REQ-025 Outbound head: periph_valid = (count != 0); periph_chan and periph_data are the head entry, driven from registers.
REQ-026 Head stability: while periph_valid=1 and periph_ready=0, periph_chan and periph_data hold stable.
REQ-027 A dequeue occurs when periph_valid=1 and periph_ready=1; the head advances by one entry.
REQ-028 io_stall = (count == DEPTH), combinational from the count.
REQ-029 Enqueue when full: accepted only if a dequeue occurs in the same cycle (count unchanged). Otherwise the write is dropped from the queue, still updates its channel register, and sets overflow.
REQ-030 Simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged. With count=0, an enqueue yields count=1 and periph_valid=1 on the next cycle; there is no fall-through.
REQ-031 overflow, once set, clears only on reset.

Configuration
REQ-032 With IO_READ_BYPASS_EN defined: when IO_write_en=1, IO_write_sel=IO_read_sel, and IO_write_sel!=0, IO_read_data = IO_write_data in the same cycle. Otherwise inbound-then-register priority applies with no inbound bypass.
REQ-033 With IO_READ_BYPASS_EN undefined: IO_read_data always returns the registered CH value, one cycle stale relative to a concurrent write.

Reset
REQ-034 On reset=1 at an edge: CH0..CH7=0, count=0, head=tail=0, overflow=0. Consequently periph_valid=0, io_stall=0, and periph_chan=periph_data=0.
REQ-035 Reset mid-transfer (periph_valid=1 and periph_ready=0) discards all queued entries; no handshake completes in the reset cycle.
REQ-036 Reset has priority over every write, inbound update, and dequeue in the same cycle.

Verification
REQ-037 Scenario: after reset, core writes ch5=0o12345 -> next cycle periph_valid=1, periph_chan=5, periph_data=0o12345, and a read of ch5 returns 0o12345.
REQ-038 Scenario: DEPTH=4, periph_ready=0, four core writes -> io_stall=1. A fifth write to ch3=0o7 -> overflow=1, CH3=0o7, count stays 4.
REQ-039 Scenario: full queue, periph_ready=1, simultaneous core write -> accepted, count stays 4, overflow stays 0, entries are drained in order over 4 cycles.
REQ-040 Scenario: core write ch2=0o111 and inbound ch2=0o222 in the same cycle -> CH2=0o111.
REQ-041 Scenario: IO_READ_BYPASS_EN defined, write ch4=0o55 while IO_read_sel=4 -> IO_read_data=0o55 in the same cycle. Undefined -> old value that cycle, 0o55 the next cycle.
REQ-042 Scenario: write ch0=0o777 -> no enqueue, and a read of ch0 returns 0.
